// File: rtl/seq_detect_pkg.sv
// Shared types and the modular step for the serial divisibility detector.
// Hit counter is enabled by defining SEQ_DETECT_MODN_HIT_CNT_EN.
package seq_detect_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_MOD_W = 8;
    localparam int DEF_CNT_W = 16;
    localparam int STEP_W    = 32;

    // base < m, so {base, b} <= 2m-1 and a single subtract reduces it.
    function automatic logic [STEP_W-1:0] mod_step(
        input logic [STEP_W-1:0] base,
        input logic              b,
        input logic [STEP_W-1:0] m
    );
        logic [STEP_W:0] t;
        t = {base, b};
        if (t >= {1'b0, m}) begin
            t = t - {1'b0, m};
        end
        return t[STEP_W-1:0];
    endfunction

endpackage

// File: rtl/seq_modn_step.sv
// Combinational wrapper around the modular step, r_next = {base, din} mod m.
// Kept separate so the arithmetic can be exercised on its own.
module seq_modn_step
    import seq_detect_pkg::*;
#(
    parameter int MOD_W = DEF_MOD_W
) (
    input  logic [MOD_W-1:0] base,
    input  logic             din,
    input  logic [MOD_W-1:0] m,
    output logic [MOD_W-1:0] r_next
);

    assign r_next = MOD_W'(mod_step(STEP_W'(base), din, STEP_W'(m)));

endmodule

// File: rtl/seq_detect_modn.sv
// Serial MSB-first divisibility detector with runtime modulus.
// Optional saturating hit counter: define SEQ_DETECT_MODN_HIT_CNT_EN.
module seq_detect_modn
    import seq_detect_pkg::*;
#(
    parameter int MOD_W = DEF_MOD_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [MOD_W-1:0] cfg_mod,
    output logic             cfg_ready,
    output logic             cfg_err,
    input  logic             sof,
    input  logic             data_valid,
    input  logic             data,
    output logic             drop,
    output logic             res_valid,
    output logic             success,
    output logic [MOD_W-1:0] remainder,
    output logic [CNT_W-1:0] hit_cnt
);

    state_t           state_q, state_d;
    logic [MOD_W-1:0] mod_q, mod_d;
    logic [MOD_W-1:0] rem_q, rem_d;
    logic             res_valid_q, res_valid_d;
    logic             success_q, success_d;
    logic             drop_q, drop_d;
    logic             cfg_err_q, cfg_err_d;

    logic             cfg_acc;
    logic             load_ok;
    logic [MOD_W-1:0] step_base;
    logic [MOD_W-1:0] step_r;

    assign cfg_ready = ~rst;
    assign cfg_acc   = cfg_valid & cfg_ready;
    assign load_ok   = cfg_acc & (cfg_mod != '0);
    assign step_base = sof ? '0 : rem_q;

    seq_modn_step #(
        .MOD_W (MOD_W)
    ) u_step (
        .base   (step_base),
        .din    (data),
        .m      (mod_q),
        .r_next (step_r)
    );

    always_comb begin
        state_d     = state_q;
        mod_d       = mod_q;
        rem_d       = rem_q;
        res_valid_d = 1'b0;
        success_d   = 1'b0;
        drop_d      = 1'b0;
        cfg_err_d   = cfg_acc & (cfg_mod == '0);

        if (load_ok) begin
            state_d = RUN;
            mod_d   = cfg_mod;
            rem_d   = '0;
        end

        // A config transfer in the same cycle always steals the bit.
        if (data_valid) begin
            if (cfg_acc || state_q == IDLE) begin
                drop_d = 1'b1;
            end else begin
                res_valid_d = 1'b1;
                rem_d       = step_r;
                success_d   = (step_r == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mod_q       <= '0;
            rem_q       <= '0;
            res_valid_q <= 1'b0;
            success_q   <= 1'b0;
            drop_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mod_q       <= mod_d;
            rem_q       <= rem_d;
            res_valid_q <= res_valid_d;
            success_q   <= success_d;
            drop_q      <= drop_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign res_valid = res_valid_q;
    assign success   = success_q;
    assign remainder = rem_q;
    assign drop      = drop_q;
    assign cfg_err   = cfg_err_q;

`ifdef SEQ_DETECT_MODN_HIT_CNT_EN
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;

    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (load_ok) begin
            hit_cnt_d = '0;
        end else if (success_d && hit_cnt_q != {CNT_W{1'b1}}) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign hit_cnt = hit_cnt_q;
`else
    assign hit_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_modn.sv
// Scoreboard bench for seq_detect_modn: random and directed bit streams
// checked against an arithmetic reference model.
module tb_seq_detect_modn;

    localparam int MOD_W = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_valid;
    logic [MOD_W-1:0] cfg_mod;
    logic             cfg_ready;
    logic             cfg_err;
    logic             sof;
    logic             data_valid;
    logic             data;
    logic             drop;
    logic             res_valid;
    logic             success;
    logic [MOD_W-1:0] remainder;
    logic [CNT_W-1:0] hit_cnt;

    seq_detect_modn #(
        .MOD_W (MOD_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_mod    (cfg_mod),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .sof        (sof),
        .data_valid (data_valid),
        .data       (data),
        .drop       (drop),
        .res_valid  (res_valid),
        .success    (success),
        .remainder  (remainder),
        .hit_cnt    (hit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rv;
        bit suc;
        int rem;
        bit drp;
        bit err;
        int hits;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 1'b0;

    // Reference model: frame value tracked modulo M with plain arithmetic.
    bit m_run;
    int m_mod;
    int m_rem;
    int m_hits;

    function automatic int hits_view();
`ifdef SEQ_DETECT_MODN_HIT_CNT_EN
        return m_hits;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_run  = 1'b0;
        m_mod  = 0;
        m_rem  = 0;
        m_hits = 0;
    endtask

    task automatic drive(input bit cv, input int cm, input bit s,
                         input bit dv, input bit d);
        exp_t e;
        e = '{default: 0};
        cfg_valid  = cv;
        cfg_mod    = MOD_W'(cm);
        sof        = s;
        data_valid = dv;
        data       = d;
        e.err = cv && (cm == 0);
        if (cv && cm != 0) begin
            m_mod  = cm;
            m_rem  = 0;
            m_run  = 1'b1;
            m_hits = 0;
        end
        if (dv) begin
            if (cv || !m_run) begin
                e.drp = 1'b1;
            end else begin
                m_rem = ((s ? 0 : m_rem) * 2 + int'(d)) % m_mod;
                e.rv  = 1'b1;
                e.suc = (m_rem == 0);
                if (e.suc && m_hits < (1 << CNT_W) - 1) m_hits++;
            end
        end
        e.rem  = m_rem;
        e.hits = hits_view();
        if (e.rv || e.drp || e.err) exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
    endtask

    task automatic load(input int m);
        drive(1, m, 0, 0, 0);
    endtask

    task automatic bits(input int n, input int val, input bit first_sof);
        for (int i = n - 1; i >= 0; i--) begin
            drive(0, 0, first_sof && (i == n - 1), 1, val[i]);
        end
    endtask

    task automatic check(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic do_reset();
        idle(2);
        mon_en = 1'b0;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check("rst_cfg_ready", int'(cfg_ready), 0);
        @(posedge clk);
        #1;
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_success", int'(success), 0);
        check("rst_drop", int'(drop), 0);
        check("rst_cfg_err", int'(cfg_err), 0);
        check("rst_remainder", int'(remainder), 0);
        check("rst_hit_cnt", int'(hit_cnt), 0);
        rst = 1'b0;
        #1;
        check("cfg_ready_after_rst", int'(cfg_ready), 1);
        @(negedge clk);
        mon_en = 1'b1;
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (success && !res_valid) begin
                n_tests++;
                n_fail++;
                $display("FAIL success_without_res_valid");
            end
            if (res_valid || drop || cfg_err) begin
                exp_t e;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: rv=%0b drop=%0b err=%0b",
                             res_valid, drop, cfg_err);
                end else begin
                    e = exp_q.pop_front();
                    if (res_valid != e.rv || success != e.suc ||
                        int'(remainder) != e.rem || drop != e.drp ||
                        cfg_err != e.err || int'(hit_cnt) != e.hits) begin
                        n_fail++;
                        $display("FAIL output: got rv=%0b suc=%0b rem=%0d drop=%0b err=%0b hit=%0d want rv=%0b suc=%0b rem=%0d drop=%0b err=%0b hit=%0d",
                                 res_valid, success, remainder, drop, cfg_err,
                                 hit_cnt, e.rv, e.suc, e.rem, e.drp, e.err,
                                 e.hits);
                    end
                end
            end
        end
    end

    initial begin
        int cm;
        rst        = 1'b1;
        cfg_valid  = 1'b0;
        cfg_mod    = '0;
        sof        = 1'b0;
        data_valid = 1'b0;
        data       = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // M=0 while idle, then a bit in IDLE is dropped.
        load(0);
        drive(0, 0, 1, 1, 1);
        idle(1);

        load(3);
        bits(3, 3'b110, 1);
        load(5);
        bits(4, 4'b1010, 1);
        bits(1, 1, 1);
        load(15);
        bits(5, 5'b11111, 1);
        load(1);
        bits(4, 4'b1011, 1);

        // Collision: config wins and the bit is lost.
        load(3);
        bits(2, 2'b10, 1);
        drive(1, 7, 1, 1, 1);
        bits(3, 3'b111, 1);
        load(0);
        bits(2, 2'b11, 0);

        load(2);
        bits(3, 3'b000, 1);
        idle(1);
        check("hit_cnt_after_zeros", int'(hit_cnt), hits_view());
        load(2);
        idle(1);
        check("hit_cnt_after_reload", int'(hit_cnt), 0);

        // Mid-frame reset returns to IDLE.
        load(9);
        bits(3, 3'b101, 1);
        do_reset();
        drive(0, 0, 1, 1, 1);
        idle(1);

        for (int i = 0; i < 3000; i++) begin
            bit cv;
            cv = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       cm = 0;
                1:       cm = $urandom_range(1, 4);
                2:       cm = 255;
                default: cm = $urandom_range(1, 255);
            endcase
            drive(cv, cm, ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end

        idle(3);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detect_modn.md
# seq_detect_modn

Serial divisibility detector, the parametrised successor of the fixed mod-3 sequence detector. Accepts an MSB-first bit stream with valid qualification and a runtime-programmable modulus M. After each accepted bit it reports whether the value accumulated since the last start-of-frame is divisible by M. It sits in the serial receive path as a checksum/alignment qualifier and shares the single system clock.

## Interface
Parameters:
- MOD_W, 8, modulus/remainder width; legal M range 1..2^MOD_W-1
- CNT_W, 16, width of hit counter (used only with SEQ_DETECT_MODN_HIT_CNT_EN)

Ports:
- clk  in  1  system clock; everything on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  modulus load request
- cfg_mod  in  MOD_W  modulus value to load
- cfg_ready  out  1  always 1 after reset; load accepted when cfg_valid & cfg_ready
- cfg_err  out  1  registered one-cycle pulse: load of M=0 rejected
- sof  in  1  start of frame, qualified by data_valid; accumulator treated as 0 before this bit
- data_valid  in  1  data bit present
- data  in  1  serial bit, MSB first
- drop  out  1  registered one-cycle pulse: valid bit discarded (IDLE or config collision)
- res_valid  out  1  one-cycle pulse, result for an accepted bit
- success  out  1  1 when res_valid and remainder == 0; else 0
- remainder  out  MOD_W  accumulated value mod M; holds between results
- hit_cnt  out  CNT_W  count of success pulses (macro-dependent)

## Operation
- States: IDLE (no legal modulus) and RUN. Reset -> IDLE.
- IDLE: valid bits are discarded with drop=1.
- Load with cfg_mod != 0: latch M, clear remainder to 0, go to RUN. Legal from IDLE or RUN.
- Load with cfg_mod == 0: cfg_err=1; M, state and remainder are unchanged.
- RUN, accepted bit b: base = sof ? 0 : r; t = {base, b} (MOD_W+1 bits); r_next = (t >= M) ? t - M : t.
- One conditional subtract is sufficient, because t <= 2M-1.
- success = (r_next == 0). With M=1, every accepted bit yields success.
- Collision (cfg accepted and data_valid in the same cycle): config wins, the bit is discarded, drop=1. A sof on that bit is also lost.
- Remainder never exceeds M-1. No overflow for any MOD_W, since accumulation is modular.
- Reset mid-frame: all state is lost and the block returns to IDLE. A new modulus load is required.

## Timing
- Reset values: state IDLE, M=0, remainder=0, res_valid=0, success=0, drop=0, cfg_err=0, hit_cnt=0. cfg_ready=0 during rst and 1 otherwise.
- Latency: bit accepted at edge t gives res_valid/success/remainder at t+1. Full throughput: one bit per cycle with no bubbles.
- A new M applies to the first bit at the edge after the load edge.
- drop and cfg_err are registered; they assert the cycle after the offending input.
- success is never asserted without res_valid.

## Configuration
- SEQ_DETECT_MODN_HIT_CNT_EN defined:
  - hit_cnt increments on each success and saturates at 2^CNT_W-1.
  - It clears on reset and on every accepted legal modulus load.
- Not defined: hit_cnt is tied to 0, the counter logic is absent, and the port stays for a stable interface.

## Structure
- Package seq_detect_pkg:
  - state enum {IDLE, RUN}
  - default MOD_W/CNT_W localparams
  - the modular step as a function (base, bit, M) -> r_next
- Optional combinational sub-module seq_modn_step wraps the step so it can be unit-tested. The top keeps all registers and the FSM.

## Test plan
- M=3, sof on first bit, bits 1,1,0 -> remainder 1,0,0; success 0,1,1.
- M=5, bits 1,0,1,0 (value 10) -> remainder 1,2,0,0; success on bits 3 and 4. Then sof with bit 1 -> remainder 1, success 0.
- MOD_W=4, M=15, bits 1,1,1,1,1 -> remainder 1,3,7,0,1; success on bit 4 only. M=1 -> success on every bit.
- Load M=0 -> cfg_err pulse, still IDLE. Valid bit 1 -> drop=1, no res_valid.
- In RUN with M=3, cfg_valid M=7 together with data_valid -> drop=1, remainder 0. Next bits 1,1,1 -> success on third bit.
- With macro: M=2, bits 0,0,0 -> hit_cnt 3. Reload -> hit_cnt 0. Without macro: hit_cnt stays 0 throughout.
